// File: rtl/jtopl_timer_bank_if.sv
// Control/status bundle between jtopl_mmr (master) and the timer bank (slave).
// Control signals flow from the register block, and status flows back.
interface jtopl_timer_bank_if #(
    parameter int N = 2,
    parameter int W = 8
);
    logic           cen16;
    logic           zero;
    logic [N*W-1:0] value;
    logic [N-1:0]   load;
    logic [N-1:0]   oneshot;
    logic [N-1:0]   flagen;
    logic [N-1:0]   clr_flag;
    logic [N-1:0]   flag;
    logic [N-1:0]   overflow;
    logic           irq_n;

    modport master (
        output cen16, zero, value, load, oneshot, flagen, clr_flag,
        input  flag, overflow, irq_n
    );

    modport slave (
        input  cen16, zero, value, load, oneshot, flagen, clr_flag,
        output flag, overflow, irq_n
    );
endinterface

// File: rtl/jtopl_timer_bank.sv
// Bank of N free-running OPL-style timers with per-channel prescaler, sticky
// masked flags, optional one-shot mode and a combined registered active-low IRQ.
module jtopl_timer_bank #(
    parameter int             N        = 2,
    parameter int             W        = 8,
    parameter logic [N*4-1:0] PRE_LOG2 = {4'd4, 4'd2}
) (
    input  logic              clk,
    input  logic              rst,
    jtopl_timer_bank_if.slave bus
);
    logic [W-1:0] cnt_q  [N];
    logic [W-1:0] cnt_d  [N];
    logic [3:0]   pcnt_q [N];
    logic [3:0]   pcnt_d [N];
    logic [N-1:0] done_q;
    logic [N-1:0] done_d;
    logic [N-1:0] load_l_q;
    logic [N-1:0] flag_q;
    logic [N-1:0] flag_d;
    logic [N-1:0] ovf_q;
    logic [N-1:0] ovf_d;
    logic         irq_n_q;
    logic         tk;
    logic [N-1:0] load_rise;

    // Prescaler terminal count; log2 values beyond the 4-bit pcnt saturate at 15.
    function automatic logic [3:0] preMax(input int ch);
        logic [3:0] lg;
        lg = PRE_LOG2[ch*4 +: 4];
        if (lg >= 4'd4) begin
            return 4'hF;
        end
        return 4'((5'd1 << lg) - 5'd1);
    endfunction

    assign tk        = bus.cen16 & bus.zero;
    assign load_rise = bus.load & ~load_l_q;

    always_comb begin
        cnt_d  = cnt_q;
        pcnt_d = pcnt_q;
        done_d = done_q;
        ovf_d  = '0;
        for (int i = 0; i < N; i++) begin
            // A load rising edge restarts the channel and swallows a coincident tick.
            if (load_rise[i]) begin
                cnt_d[i]  = bus.value[i*W +: W];
                pcnt_d[i] = '0;
                done_d[i] = 1'b0;
            end else if (tk && bus.load[i] && !done_q[i]) begin
                if (pcnt_q[i] == preMax(i)) begin
                    pcnt_d[i] = '0;
                    if (cnt_q[i] == {W{1'b1}}) begin
                        cnt_d[i] = bus.value[i*W +: W];
                        ovf_d[i] = 1'b1;
                        if (bus.oneshot[i]) begin
                            done_d[i] = 1'b1;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + W'(1);
                    end
                end else begin
                    pcnt_d[i] = pcnt_q[i] + 4'd1;
                end
            end
        end
        // Set beats clear so an overflow landing on a clear pulse is never lost.
        flag_d = (flag_q & ~bus.clr_flag) | (ovf_d & bus.flagen);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i]  <= '0;
                pcnt_q[i] <= '0;
            end
            done_q   <= '0;
            load_l_q <= '0;
            flag_q   <= '0;
            ovf_q    <= '0;
            irq_n_q  <= 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i]  <= cnt_d[i];
                pcnt_q[i] <= pcnt_d[i];
            end
            done_q   <= done_d;
            load_l_q <= bus.load;
            flag_q   <= flag_d;
            ovf_q    <= ovf_d;
            irq_n_q  <= ~|flag_q;
        end
    end

    assign bus.flag     = flag_q;
    assign bus.overflow = ovf_q;
    assign bus.irq_n    = irq_n_q;
endmodule
